// File: rtl/count_seq_checker_pkg.sv
// count_chk_pkg: shared state encoding, default counter width and next-q prediction helper
package count_chk_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } state_e;

    // Counter reset beats load, load beats increment; caller truncates to its width
    function automatic logic [31:0] next_count(input logic [31:0] q, input logic ld,
                                               input logic [31:0] d, input logic rst);
        return rst ? 32'd0 : ld ? d : q + 32'd1;
    endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// sat_counter: EW-bit saturating incrementer with synchronous clear; also exposes its next value
module sat_counter #(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [EW-1:0] count,
    output logic [EW-1:0] count_nxt
);

    logic [EW-1:0] count_q, count_d;

    // Clear wins over increment; increment stops at all-ones
    always_comb begin
        count_d = clr ? '0 : (inc && count_q != '1) ? count_q + EW'(1) : count_q;
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count     = count_q;
    assign count_nxt = count_d;

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors a loadable up counter, flags mismatches/wraps, counts errors.
// Optional capture of last expected/actual values under COUNT_SEQ_CHECKER_CAPTURE_EN.
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int W         = CNT_W,
    parameter int EW        = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          chk_en,
    input  logic          clr_err,
    input  logic          cnt_rst,
    input  logic          cnt_load_en,
    input  logic [W-1:0]  cnt_data,
    input  logic [W-1:0]  cnt_q,
    output logic [1:0]    state,
    output logic          mismatch_pulse,
    output logic          wrap_pulse,
    output logic          err_sticky,
    output logic [EW-1:0] err_count,
    output logic [W-1:0]  exp_cap,
    output logic [W-1:0]  act_cap
);

    state_e        state_q, state_d;
    logic [W-1:0]  p_q_q, p_q_d, p_d_q, p_d_d;
    logic          p_ld_q, p_ld_d, p_rst_q, p_rst_d;
    logic          mismatch_q, mismatch_d, wrap_q, wrap_d, sticky_q, sticky_d;
    logic [W-1:0]  exp_q;
    logic          cmp, mm;
    logic [EW-1:0] err_nxt;

    // Sample the counter every edge, predict its next q and evaluate the compare
    always_comb begin
        p_q_d      = cnt_q;
        p_d_d      = cnt_data;
        p_ld_d     = cnt_load_en;
        p_rst_d    = cnt_rst;
        exp_q      = W'(next_count(32'(p_q_q), p_ld_q, 32'(p_d_q), p_rst_q));
        cmp        = (state_q == TRACK) || (state_q == FAULT);
        mm         = cmp && (cnt_q != exp_q);
        mismatch_d = mm;
        wrap_d     = cmp && !p_rst_q && !p_ld_q && (p_q_q == '1) && (cnt_q == '0);
        sticky_d   = !clr_err && (sticky_q || mm);
    end

    // Next state: enable gates everything, PRIME lasts one edge, FAULT on the post-increment count
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = PRIME;
            PRIME:   state_d = TRACK;
            default: state_d = (err_nxt >= EW'(ERR_LIMIT)) ? FAULT : TRACK;
        endcase
        if (!chk_en) state_d = IDLE;
    end

    // State, samples and registered flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            p_q_q      <= '0;
            p_d_q      <= '0;
            p_ld_q     <= 1'b0;
            p_rst_q    <= 1'b0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q_q      <= p_q_d;
            p_d_q      <= p_d_d;
            p_ld_q     <= p_ld_d;
            p_rst_q    <= p_rst_d;
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
            sticky_q   <= sticky_d;
        end
    end

    sat_counter #(.EW(EW)) u_err (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_err),
        .inc       (mm),
        .count     (err_count),
        .count_nxt (err_nxt)
    );

`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    logic [W-1:0] exp_cap_q, exp_cap_d, act_cap_q, act_cap_d;

    // Hold the last mismatching pair; only reset clears it
    always_comb begin
        exp_cap_d = mm ? exp_q : exp_cap_q;
        act_cap_d = mm ? cnt_q : act_cap_q;
    end

    // Capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_cap_q <= '0;
            act_cap_q <= '0;
        end else begin
            exp_cap_q <= exp_cap_d;
            act_cap_q <= act_cap_d;
        end
    end

    assign exp_cap = exp_cap_q;
    assign act_cap = act_cap_q;
`else
    assign exp_cap = '0;
    assign act_cap = '0;
`endif

    assign state          = state_q;
    assign mismatch_pulse = mismatch_q;
    assign wrap_pulse     = wrap_q;
    assign err_sticky     = sticky_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed plus randomized check of two checker configurations against a behavioural model
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       rst, chk_en, clr_err, cnt_rst, cnt_load_en;
    logic [3:0] cnt_data, cnt_q;
    logic [1:0] st0, st1, ec1;
    logic [7:0] ec0;
    logic       mm0, mm1, wr0, wr1, sk0, sk1;
    logic [3:0] ex0, ac0, ex1, ac1;

    always #5 clk = ~clk;

    count_seq_checker #(.W(4), .EW(8), .ERR_LIMIT(4)) dut0 (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clr_err(clr_err), .cnt_rst(cnt_rst),
        .cnt_load_en(cnt_load_en), .cnt_data(cnt_data), .cnt_q(cnt_q), .state(st0),
        .mismatch_pulse(mm0), .wrap_pulse(wr0), .err_sticky(sk0), .err_count(ec0),
        .exp_cap(ex0), .act_cap(ac0));

    count_seq_checker #(.W(4), .EW(2), .ERR_LIMIT(3)) dut1 (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clr_err(clr_err), .cnt_rst(cnt_rst),
        .cnt_load_en(cnt_load_en), .cnt_data(cnt_data), .cnt_q(cnt_q), .state(st1),
        .mismatch_pulse(mm1), .wrap_pulse(wr1), .err_sticky(sk1), .err_count(ec1),
        .exp_cap(ex1), .act_cap(ac1));

    int n_cmp = 0, n_fail = 0;
    int m_st[2], m_err[2];
    int m_mm, m_wr, m_sk, m_ex, m_ac;
    int pq, pld, pd, prst;
    int wraps, cq;

    function automatic int err_max(input int k);
        return k == 0 ? 255 : 3;
    endfunction

    function automatic int err_lim(input int k);
        return k == 0 ? 4 : 3;
    endfunction

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k]  = 0;
            m_err[k] = 0;
        end
        {m_mm, m_wr, m_sk, m_ex, m_ac, pq, pld, pd, prst} = '0;
    endtask

    task automatic model_step(input int ce, input int clr, input int cr, input int ld,
                              input int d, input int q);
        int e, cmp;
        e    = prst != 0 ? 0 : pld != 0 ? pd : (pq + 1) % 16;
        cmp  = (m_st[0] >= 2) ? 1 : 0;
        m_mm = (cmp != 0 && q != e) ? 1 : 0;
        m_wr = (cmp != 0 && prst == 0 && pld == 0 && pq == 15 && q == 0) ? 1 : 0;
        if (m_mm != 0) begin
            m_ex = e;
            m_ac = q;
        end
        m_sk = clr != 0 ? 0 : (m_sk | m_mm);
        for (int k = 0; k < 2; k++) begin
            m_err[k] = clr != 0 ? 0 : (m_err[k] + m_mm > err_max(k) ? err_max(k) : m_err[k] + m_mm);
            if (ce == 0)          m_st[k] = 0;
            else if (m_st[k] < 2) m_st[k] = m_st[k] + 1;
            else                  m_st[k] = m_err[k] >= err_lim(k) ? 3 : 2;
        end
        pq = q; pld = ld; pd = d; prst = cr;
    endtask

    task automatic check_all();
        chk("state0", int'(st0), m_st[0]);
        chk("state1", int'(st1), m_st[1]);
        chk("mismatch0", int'(mm0), m_mm);
        chk("mismatch1", int'(mm1), m_mm);
        chk("wrap0", int'(wr0), m_wr);
        chk("wrap1", int'(wr1), m_wr);
        chk("sticky0", int'(sk0), m_sk);
        chk("sticky1", int'(sk1), m_sk);
        chk("errcnt0", int'(ec0), m_err[0]);
        chk("errcnt1", int'(ec1), m_err[1]);
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
        chk("expcap0", int'(ex0), m_ex);
        chk("actcap0", int'(ac0), m_ac);
        chk("expcap1", int'(ex1), m_ex);
        chk("actcap1", int'(ac1), m_ac);
`else
        chk("expcap0", int'(ex0), 0);
        chk("actcap0", int'(ac0), 0);
        chk("expcap1", int'(ex1), 0);
        chk("actcap1", int'(ac1), 0);
`endif
    endtask

    task automatic step(input int ce, input int clr, input int cr, input int ld,
                        input int d, input int q);
        chk_en      = ce[0];
        clr_err     = clr[0];
        cnt_rst     = cr[0];
        cnt_load_en = ld[0];
        cnt_data    = d[3:0];
        cnt_q       = q[3:0];
        model_step(ce, clr, cr, ld, d, q);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        {chk_en, clr_err, cnt_rst, cnt_load_en} = '0;
        cnt_data = '0;
        cnt_q    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_state", int'(st0), 0);
        chk("rst_errcnt", int'(ec0), 0);
        rst = 1'b0;

        wraps = 0;
        for (int i = 0; i < 18; i++) begin
            step(1, 0, 0, 0, 0, i % 16);
            if (i == 0) chk("prime_after_en", int'(st0), 1);
            if (i == 1) chk("track_after_prime", int'(st0), 2);
            wraps += int'(wr0);
        end
        chk("freerun_wraps", wraps, 1);
        chk("freerun_errs", int'(ec0), 0);

        for (int v = 2; v <= 6; v++) step(1, 0, 0, v == 6 ? 1 : 0, 10, v);
        chk("load_ok", int'(mm0), 0);
        step(1, 0, 0, 0, 0, 11);
        chk("load_bad_mm", int'(mm0), 1);
        chk("load_bad_cnt", int'(ec0), 1);
        chk("load_bad_sticky", int'(sk0), 1);
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
        chk("load_expcap", int'(ex0), 10);
        chk("load_actcap", int'(ac0), 11);
`endif
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 5);
        chk("ew2_fault", int'(st1), 3);
        step(1, 0, 0, 0, 0, 9);
        chk("fault_state", int'(st0), 3);
        chk("fault_cnt", int'(ec0), 4);
        chk("ew2_sat", int'(ec1), 3);
        step(1, 1, 0, 0, 0, 3);
        chk("clr_mm_pulse", int'(mm0), 1);
        chk("clr_cnt", int'(ec0), 0);
        chk("clr_sticky", int'(sk0), 0);
        chk("clr_state", int'(st0), 2);
        chk("clr_cnt_ew2", int'(ec1), 0);

        step(1, 0, 0, 1, 15, 4);
        step(1, 0, 1, 1, 9, 15);
        step(1, 0, 0, 0, 0, 0);
        chk("rstld_mm", int'(mm0), 0);
        chk("rstld_wrap", int'(wr0), 0);

        step(1, 0, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 8);
        step(1, 0, 0, 0, 0, 2);
        chk("pre_rst_cnt", int'(ec0), 3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_state", int'(st0), 0);
        chk("async_cnt", int'(ec0), 0);
        chk("async_sticky", int'(sk0), 0);
        check_all();
        rst = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        chk("reentry_prime", int'(st0), 1);
        step(1, 0, 0, 0, 0, 1);
        chk("reentry_track", int'(st0), 2);

        cq = 2;
        for (int i = 0; i < 3000; i++) begin
            int ce, clr, cr, ld, d, q;
            ce  = $urandom_range(0, 99) < 97 ? 1 : 0;
            clr = $urandom_range(0, 49) == 0 ? 1 : 0;
            cr  = $urandom_range(0, 19) == 0 ? 1 : 0;
            ld  = $urandom_range(0, 7) == 0 ? 1 : 0;
            d   = int'($urandom_range(0, 15));
            q   = $urandom_range(0, 14) == 0 ? int'($urandom_range(0, 15)) : cq;
            step(ce, clr, cr, ld, d, q);
            cq  = cr != 0 ? 0 : ld != 0 ? d : (q + 1) % 16;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
